// File: rtl/conv_act_packer_if.sv
// Stream bundle for the activation packer: conv-result input stream and
// packed-pixel output stream. The design sits on the slave side.
interface conv_act_packer_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int LANES_IN       = 4,
    parameter int BEATS_PER_WORD = 4
);
    localparam int BEAT_W = DATA_WIDTH * LANES_IN;
    localparam int WORD_W = BEAT_W * BEATS_PER_WORD;
    localparam int KEEP_W = WORD_W / 8;

    logic [BEAT_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;

    logic [WORD_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/conv_act_packer.sv
// Applies a per-frame activation (bypass / ReLU / LeakyReLU 1/8) to signed conv
// lanes on acceptance and packs several input beats into one wide output word.
module conv_act_packer #(
    parameter int DATA_WIDTH     = 16,
    parameter int LANES_IN       = 4,
    parameter int BEATS_PER_WORD = 4
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic [1:0]          act_mode,
    conv_act_packer_if.slave    axis,
    output logic [15:0]         word_count,
    output logic                frame_done
);
    localparam int BEAT_W     = DATA_WIDTH * LANES_IN;
    localparam int WORD_W     = BEAT_W * BEATS_PER_WORD;
    localparam int KEEP_W     = WORD_W / 8;
    localparam int BEAT_BYTES = BEAT_W / 8;
    localparam int CNT_W      = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;

    logic [1:0]        mode_r;
    logic              first_beat_r;
    logic [CNT_W-1:0]  beat_cnt_r;
    logic [BEAT_W-1:0] stage_r [BEATS_PER_WORD];

    logic              accept_s;
    logic              last_beat_s;
    logic              emit_s;
    logic              out_hs_s;
    logic [1:0]        mode_eff_s;
    logic [BEAT_W-1:0] act_beat_s;
    logic [WORD_W-1:0] word_s;
    logic [KEEP_W-1:0] keep_s;

    // Negative lanes: ReLU clamps to zero, LeakyReLU shifts arithmetically (floor).
    function automatic logic [DATA_WIDTH-1:0] activate(
        input logic [DATA_WIDTH-1:0] x,
        input logic [1:0]            mode
    );
        logic signed [DATA_WIDTH-1:0] sx;
        logic        [DATA_WIDTH-1:0] y;
        sx = x;
        case (mode)
            2'd1: begin
                if (x[DATA_WIDTH-1]) y = {DATA_WIDTH{1'b0}};
                else                 y = x;
            end
            2'd2: begin
                if (x[DATA_WIDTH-1]) y = sx >>> 3'd3;
                else                 y = x;
            end
            default: y = x;
        endcase
        return y;
    endfunction

    assign axis.s_axis_tready = !axis.m_axis_tvalid || axis.m_axis_tready;

    // Handshake decode; the first beat of a frame uses the live mode input.
    always_comb begin
        accept_s    = axis.s_axis_tvalid && axis.s_axis_tready;
        last_beat_s = axis.s_axis_tlast || (beat_cnt_r == CNT_W'(BEATS_PER_WORD - 1));
        emit_s      = accept_s && last_beat_s;
        out_hs_s    = axis.m_axis_tvalid && axis.m_axis_tready;
        mode_eff_s  = first_beat_r ? act_mode : mode_r;
    end

    // Lane-wise activation of the incoming beat.
    always_comb begin
        act_beat_s = {BEAT_W{1'b0}};
        for (int l = 0; l < LANES_IN; l++) begin
            act_beat_s[l*DATA_WIDTH +: DATA_WIDTH] =
                activate(axis.s_axis_tdata[l*DATA_WIDTH +: DATA_WIDTH], mode_eff_s);
        end
    end

    // Word assembly: staged beats below the counter, current beat at it, zeros above.
    always_comb begin
        word_s = {WORD_W{1'b0}};
        keep_s = {KEEP_W{1'b0}};
        for (int b = 0; b < BEATS_PER_WORD; b++) begin
            if (CNT_W'(b) < beat_cnt_r) begin
                word_s[b*BEAT_W +: BEAT_W]         = stage_r[b];
                keep_s[b*BEAT_BYTES +: BEAT_BYTES] = {BEAT_BYTES{1'b1}};
            end else if (CNT_W'(b) == beat_cnt_r) begin
                word_s[b*BEAT_W +: BEAT_W]         = act_beat_s;
                keep_s[b*BEAT_BYTES +: BEAT_BYTES] = {BEAT_BYTES{1'b1}};
            end else begin
                word_s[b*BEAT_W +: BEAT_W]         = {BEAT_W{1'b0}};
                keep_s[b*BEAT_BYTES +: BEAT_BYTES] = {BEAT_BYTES{1'b0}};
            end
        end
    end

    // Beat staging, frame-start tracking and per-frame mode latch.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt_r   <= {CNT_W{1'b0}};
            first_beat_r <= 1'b1;
            mode_r       <= 2'd0;
            for (int b = 0; b < BEATS_PER_WORD; b++) begin
                stage_r[b] <= {BEAT_W{1'b0}};
            end
        end else if (accept_s) begin
            first_beat_r <= axis.s_axis_tlast;
            if (first_beat_r) begin
                mode_r <= act_mode;
            end
            if (emit_s) begin
                beat_cnt_r <= {CNT_W{1'b0}};
            end else begin
                beat_cnt_r          <= beat_cnt_r + CNT_W'(1);
                stage_r[beat_cnt_r] <= act_beat_s;
            end
        end
    end

    // Output word register; a new word may replace one leaving on the same edge.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            axis.m_axis_tdata  <= {WORD_W{1'b0}};
            axis.m_axis_tkeep  <= {KEEP_W{1'b0}};
            axis.m_axis_tlast  <= 1'b0;
            axis.m_axis_tvalid <= 1'b0;
        end else if (emit_s) begin
            axis.m_axis_tdata  <= word_s;
            axis.m_axis_tkeep  <= keep_s;
            axis.m_axis_tlast  <= axis.s_axis_tlast;
            axis.m_axis_tvalid <= 1'b1;
        end else if (out_hs_s) begin
            axis.m_axis_tvalid <= 1'b0;
        end
    end

    // Per-frame word counter; it clears while frame_done is showing the final count.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            word_count <= 16'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_hs_s && axis.m_axis_tlast;
            if (frame_done) begin
                word_count <= out_hs_s ? 16'd1 : 16'd0;
            end else if (out_hs_s) begin
                word_count <= word_count + 16'd1;
            end
        end
    end
endmodule

// File: doc/conv_act_packer.md
CONV_ACT_PACKER -- requirements
Module: conv_act_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 16; width of one signed result lane.
REQ-002 Parameter LANES_IN, default 4; lanes per input beat (input width = DATA_WIDTH*LANES_IN = 64).
REQ-003 Parameter BEATS_PER_WORD, default 4; input beats packed per output word (output width = 256).
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 aresetn  input  1  asynchronous, active-low reset.
REQ-006 act_mode  input  2  0 = bypass, 1 = ReLU, 2 = LeakyReLU (slope 1/8), 3 = bypass; from AXI GPIO.
REQ-007 s_axis_tdata  input  64  four signed 16-bit conv results; lane i = bits [16i+15:16i].
REQ-008 s_axis_tvalid, s_axis_tlast  input  1 each  upstream stream from conv stage.
REQ-009 s_axis_tready  output  1  upstream backpressure.
REQ-010 m_axis_tdata  output  256  packed activated pixels to DMA.
REQ-011 m_axis_tkeep  output  32  byte-valid mask of m_axis_tdata.
REQ-012 m_axis_tvalid, m_axis_tlast  output  1 each; m_axis_tready  input  1.
REQ-013 word_count  output  16  output words handshaken in current frame.
REQ-014 frame_done  output  1  one-cycle pulse after the tlast word is handshaken.

Function
REQ-015 Input beat accepted when s_axis_tvalid && s_axis_tready; output word transferred when m_axis_tvalid && m_axis_tready.
REQ-016 s_axis_tready SHALL equal (!m_axis_tvalid || m_axis_tready), combinational, no dependence on s_axis_tvalid.
REQ-017 act_mode SHALL be latched on the first accepted beat of each frame (beat after reset or after a tlast beat) and used for the whole frame.
REQ-018 Per lane, bypass: y = x; ReLU: y = (x<0) ? 0 : x; LeakyReLU: y = (x<0) ? x>>>3 (arithmetic, rounds toward minus infinity) : x; output width 16, no saturation needed.
REQ-019 Activation SHALL be applied on acceptance; staged beat k (0..3) of a word occupies m_axis_tdata bits [64k+63:64k].
REQ-020 A 2-bit beat counter SHALL count accepted beats 0..3 and wrap to 0 when a word is emitted.
REQ-021 When the 4th beat or a tlast beat is accepted, the word SHALL load the output register on that edge; m_axis_tvalid rises the next cycle (latency 1 cycle from final beat).
REQ-022 Partial word on tlast: unfilled beat slots SHALL be zero; m_axis_tkeep = 8 ones per filled beat from LSB (e.g. 2 beats -> 32'h0000FFFF); full word -> 32'hFFFFFFFF.
REQ-023 m_axis_tlast SHALL be 1 only on the word containing the input tlast beat.
REQ-024 m_axis_tdata/tkeep/tlast SHALL hold stable while m_axis_tvalid && !m_axis_tready.
REQ-025 Simultaneous output handshake and final-beat acceptance SHALL load the new word with m_axis_tvalid remaining 1 (no bubble).
REQ-026 word_count SHALL increment on each output handshake, clear to 0 the cycle after the tlast-word handshake, wrap at 65535.
REQ-027 frame_done SHALL pulse high exactly one cycle, the cycle after the tlast-word handshake.
REQ-028 Beats accepted while not ready are impossible by construction; s_axis_tdata when not accepted SHALL be ignored.

Reset
REQ-029 aresetn low SHALL immediately force m_axis_tvalid, m_axis_tlast, frame_done = 0, m_axis_tdata = 0, m_axis_tkeep = 0, word_count = 0, beat counter = 0, latched mode = bypass.
REQ-030 s_axis_tready SHALL be 1 during and after reset (output register empty).
REQ-031 Reset asserted mid-frame SHALL discard all staged beats and any pending output word; the first beat after release starts a new frame.

Verification
REQ-032 Bypass, 4 beats lanes 0x0001..0x0010, m_axis_tready=1 -> one word, tdata = beats concatenated (beat0 at LSB), tkeep=32'hFFFFFFFF, tvalid 1 cycle after beat 4.
REQ-033 LeakyReLU, lanes {-16,-1,-9,100} -> {-2,-1,-2,100}; ReLU same input -> {0,0,0,100}.
REQ-034 Frame of 6 beats, tlast on beat 6 -> word 1 full tlast=0, word 2 tkeep=32'h0000FFFF, upper 128 bits zero, tlast=1, frame_done pulse, word_count 2 then 0.
REQ-035 m_axis_tready held 0 for 10 cycles with word pending -> s_axis_tready=0, tdata/tkeep stable; release -> transfer, streaming resumes with no lost/duplicated beats.
REQ-036 act_mode changed from 2 to 1 mid-frame -> remainder of frame still LeakyReLU; next frame uses ReLU.
REQ-037 aresetn pulsed low after 2 beats staged -> outputs zero immediately; next 4 beats produce one word containing only post-reset data.
